// File: rtl/tetris_pkg.sv
// Shared types and default timing constants for the playfield
// movement logic.
package tetris_pkg;

  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_LEFT  = 3'd1,
    CMD_RIGHT = 3'd2,
    CMD_ROT   = 3'd3,
    CMD_DOWN  = 3'd4
  } move_cmd_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OFFER = 2'd1,
    S_WAIT  = 2'd2,
    S_LOCK  = 2'd3
  } sched_state_t;

  localparam int GRAV_BASE_DEF    = 42_500_000;
  localparam int GRAV_STEP_DEF    = 2_500_000;
  localparam int GRAV_MIN_DEF     = 5_000_000;
  localparam int SOFT_PERIOD_DEF  = 2_500_000;
  localparam int HORIZ_PERIOD_DEF = 2_500_000;

endpackage

// File: rtl/move_scheduler_timer.sv
// Free-running period timer; expire pulses when the count reaches
// period-1, or overshoots it after a period shrink.
module period_timer #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic             clr,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;
  logic             hit;

  assign hit    = cnt >= (period - CNT_W'(1));
  assign expire = en & hit & ~clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= hit ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/move_scheduler.sv
// Gravity / auto-repeat timing and arbitration of piece moves onto
// the shared collision-checking move engine.
module move_scheduler
  import tetris_pkg::*;
#(
  parameter int GRAV_BASE    = GRAV_BASE_DEF,
  parameter int GRAV_STEP    = GRAV_STEP_DEF,
  parameter int GRAV_MIN     = GRAV_MIN_DEF,
  parameter int SOFT_PERIOD  = SOFT_PERIOD_DEF,
  parameter int HORIZ_PERIOD = HORIZ_PERIOD_DEF,
  parameter int CNT_W        = 26,
  parameter int LEVEL_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [LEVEL_W-1:0] level,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_rotate,
  input  logic               btn_down,
  input  logic               btn_drop,
  output logic               mv_valid,
  output logic [2:0]         mv_cmd,
  input  logic               mv_ready,
  input  logic               mv_done,
  input  logic               mv_blocked,
  output logic               lock_req,
  output logic               busy
);

  localparam int PW = CNT_W + LEVEL_W;

  sched_state_t     state;
  move_cmd_t        cmd_q;
  logic             drop_mode;
  logic             grav_pend, hz_pend, rot_pend, drop_pend;
  logic             hz_dir;
  logic             rot_q, drop_q;

  logic [PW-1:0]    dec, per_w;
  logic [CNT_W-1:0] grav_per;
  logic             g_exp, h_exp;
  logic             rot_rise, drop_rise, hz_set;
  logic             xfer, in_lock;
  logic             clr_grav, clr_drop, clr_rot, clr_hz;

  // Clamp before subtracting so high levels never wrap.
  always_comb begin
    dec   = PW'(level) * PW'(GRAV_STEP);
    per_w = PW'(GRAV_MIN);
    if (dec + PW'(GRAV_MIN) < PW'(GRAV_BASE))
      per_w = PW'(GRAV_BASE) - dec;
    if (btn_down && per_w > PW'(SOFT_PERIOD))
      per_w = PW'(SOFT_PERIOD);
  end

  assign grav_per = CNT_W'(per_w);
  assign in_lock  = (state == S_LOCK);

  period_timer #(.CNT_W(CNT_W)) u_grav (
    .clk    (clk),
    .rst    (rst),
    .en     (run),
    .period (grav_per),
    .clr    (in_lock),
    .expire (g_exp)
  );

  period_timer #(.CNT_W(CNT_W)) u_horiz (
    .clk    (clk),
    .rst    (rst),
    .en     (run),
    .period (CNT_W'(HORIZ_PERIOD)),
    .clr    (1'b0),
    .expire (h_exp)
  );

  assign rot_rise  = run & btn_rotate & ~rot_q;
  assign drop_rise = run & btn_drop & ~drop_q;
  assign hz_set    = h_exp & (btn_left ^ btn_right);
  assign xfer      = (state == S_OFFER) & mv_ready;

  assign clr_grav = in_lock |
                    (xfer & (cmd_q == CMD_DOWN) & ~drop_mode);
  assign clr_drop = xfer & (cmd_q == CMD_DOWN) & drop_mode;
  assign clr_rot  = xfer & (cmd_q == CMD_ROT);
  assign clr_hz   = xfer &
                    ((cmd_q == CMD_LEFT) | (cmd_q == CMD_RIGHT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rot_q     <= 1'b0;
      drop_q    <= 1'b0;
      grav_pend <= 1'b0;
      hz_pend   <= 1'b0;
      hz_dir    <= 1'b0;
      rot_pend  <= 1'b0;
      drop_pend <= 1'b0;
    end else begin
      rot_q     <= btn_rotate;
      drop_q    <= btn_drop;
      grav_pend <= g_exp | (grav_pend & ~clr_grav);
      drop_pend <= drop_rise | (drop_pend & ~clr_drop);
      rot_pend  <= rot_rise | (rot_pend & ~clr_rot);
      hz_pend   <= hz_set | (hz_pend & ~clr_hz);
      if (hz_set)
        hz_dir <= btn_right;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cmd_q     <= CMD_NONE;
      drop_mode <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) begin
            priority case (1'b1)
              drop_pend: begin
                cmd_q     <= CMD_DOWN;
                drop_mode <= 1'b1;
                state     <= S_OFFER;
              end
              grav_pend: begin
                cmd_q <= CMD_DOWN;
                state <= S_OFFER;
              end
              rot_pend: begin
                cmd_q <= CMD_ROT;
                state <= S_OFFER;
              end
              hz_pend: begin
                cmd_q <= hz_dir ? CMD_RIGHT : CMD_LEFT;
                state <= S_OFFER;
              end
              default: ;
            endcase
          end
        end
        S_OFFER: begin
          if (mv_ready)
            state <= S_WAIT;
        end
        S_WAIT: begin
          if (mv_done) begin
            if (cmd_q == CMD_DOWN && mv_blocked)
              state <= S_LOCK;
            else if (cmd_q == CMD_DOWN && drop_mode)
              state <= S_OFFER;
            else
              state <= S_IDLE;
          end
        end
        S_LOCK: begin
          drop_mode <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mv_valid = (state == S_OFFER);
  assign mv_cmd   = mv_valid ? cmd_q : CMD_NONE;
  assign lock_req = in_lock;
  assign busy     = (state != S_IDLE);

endmodule
